multi_cycle_ctrl: RTL

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: five-state FSM, datapath strobe decode,
// and retired-instruction counter.
module multi_cycle_ctrl (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] instruction,
  input  logic        Zero,
  output logic [1:0]  PCsrc,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic [2:0]  ALUop,
  output logic [2:0]  State,
  output logic [31:0] InstCount,
  output logic        Illegal
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  state_e      state_q, state_d;
  logic [5:0]  op_q, funct_q;
  logic [31:0] count_q;
  logic        inc;
  logic        is_r, op_ok, fn_ok;
  logic [2:0]  alu_r;
  logic        unused_instr;

  assign unused_instr = ^instruction[25:6];

  always_comb begin
    fn_ok = 1'b1;
    alu_r = 3'b000;
    case (funct_q)
      FnAdd:   alu_r = 3'b000;
      FnSub:   alu_r = 3'b001;
      FnAnd:   alu_r = 3'b010;
      FnOr:    alu_r = 3'b011;
      FnSlt:   alu_r = 3'b100;
      default: fn_ok = 1'b0;
    endcase
  end

  assign is_r  = (op_q == OpR);
  assign op_ok = is_r || (op_q == OpLw) || (op_q == OpSw) || (op_q == OpBeq) ||
                 (op_q == OpBne) || (op_q == OpAddi) || (op_q == OpJ);

  // Clr gates every output combinationally so nothing strobes during reset.
  always_comb begin
    state_d  = StIf;
    inc      = 1'b0;
    PCsrc    = 2'b00;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    ALUop    = 3'b000;
    Illegal  = 1'b0;
    if (!Clr) begin
      case (state_q)
        StIf: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StId;
        end
        StId: begin
          if (!op_ok || (is_r && !fn_ok)) begin
            Illegal = 1'b1;
          end else if (op_q == OpJ) begin
            PCWrite = 1'b1;
            PCsrc   = 2'b10;
            inc     = 1'b1;
          end else begin
            state_d = StEx;
          end
        end
        StEx: begin
          if (is_r) begin
            ALUop   = alu_r;
            state_d = StWb;
          end else if (op_q == OpAddi) begin
            ALUSrc  = 1'b1;
            state_d = StWb;
          end else if (op_q == OpLw || op_q == OpSw) begin
            ALUSrc  = 1'b1;
            state_d = StMem;
          end else if (op_q == OpBeq || op_q == OpBne) begin
            ALUop   = 3'b001;
            PCsrc   = 2'b01;
            PCWrite = (op_q == OpBeq) ? Zero : ~Zero;
            inc     = 1'b1;
          end
        end
        StMem: begin
          if (op_q == OpLw) begin
            MemRead = 1'b1;
            state_d = StWb;
          end else if (op_q == OpSw) begin
            MemWrite = 1'b1;
            inc      = 1'b1;
          end
        end
        StWb: begin
          RegWrite = 1'b1;
          RegDst   = is_r;
          MemtoReg = (op_q == OpLw);
          inc      = 1'b1;
        end
        default: state_d = StIf;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= StIf;
      op_q    <= 6'd0;
      funct_q <= 6'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == StIf) begin
        op_q    <= instruction[31:26];
        funct_q <= instruction[5:0];
      end
      if (inc) count_q <= count_q + 32'd1;
    end
  end

  assign State     = state_q;
  assign InstCount = count_q;

endmodule
